sub_byte_sequencer: RTL and testbench

Multi-byte subtraction sequencer. Computes an NBYTES×8-bit difference `a − b − bin` by running a single 8-bit ripple-borrow subtract slice once per clock, least-significant byte first, with a registered borrow chained between bytes. Sits between a valid/ready operand source and a valid/ready result sink. Use it wherever wide subtraction is needed and area matters more than latency.

---
 rtl/sub_byte_sequencer.sv | 127 ++++++++++++
 tb/tb_sub_byte_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sub_byte_sequencer.sv
// Multi-byte subtraction sequencer: one 8-bit ripple-borrow slice reused LSB-first across NBYTES cycles.
// Optional zero/ovf result flags are built when SUB_SEQ_FLAGS_EN is defined.
module sub_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   diff,
    output logic                  bout,
    output logic                  busy
`ifdef SUB_SEQ_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  ovf
`endif
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    opa, opb;
    logic [IDXW-1:0] idx;
    logic            borrow;
    logic [8:0]      slice;
    logic [W-1:0]    diff_upd;

    // Bit 8 of the 9-bit result is the borrow out of this byte.
    function automatic logic [8:0] sub_slice(input logic [7:0] x, input logic [7:0] y,
                                             input logic bi);
        return {1'b0, x} - {1'b0, y} - {8'b0, bi};
    endfunction

    assign slice = sub_slice(opa[8*idx +: 8], opb[8*idx +: 8], borrow);

    always_comb begin
        diff_upd             = diff;
        diff_upd[8*idx +: 8] = slice[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands are not reset: they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && !rst) begin
            opa <= a;
            opb <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff   <= '0;
            bout   <= 1'b0;
            borrow <= 1'b0;
            idx    <= '0;
`ifdef SUB_SEQ_FLAGS_EN
            zero   <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        borrow <= bin;
                        idx    <= '0;
                        diff   <= '0;
                    end
                end
                RUN: begin
                    diff   <= diff_upd;
                    borrow <= slice[8];
                    if (idx == LAST) begin
                        idx  <= '0;
                        bout <= slice[8];
`ifdef SUB_SEQ_FLAGS_EN
                        zero <= (diff_upd == '0);
                        ovf  <= (opa[W-1] ^ opb[W-1]) & (slice[7] ^ opa[W-1]);
`endif
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_byte_sequencer.sv
// Directed bench for sub_byte_sequencer (NBYTES = 4): vector table plus backpressure and mid-run reset sequences.
module tb_sub_byte_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
`ifdef SUB_SEQ_FLAGS_EN
    logic         zero, ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    sub_byte_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .busy(busy)
`ifdef SUB_SEQ_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_zero;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        bin      = v.bin;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1 cycles++;
        end
        check({tag, " latency"}, 64'(cycles), 64'd4);
        check({tag, " diff"}, 64'(diff), 64'(v.exp_diff));
        check({tag, " bout"}, 64'(bout), 64'(v.exp_bout));
`ifdef SUB_SEQ_FLAGS_EN
        check({tag, " zero"}, 64'(zero), 64'(v.exp_zero));
        check({tag, " ovf"}, 64'(ovf), 64'(v.exp_ovf));
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " idle again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] held_diff;
        logic         held_bout;
        vec_t         v;

        vecs[0] = '{32'h12345678, 32'h00000001, 1'b0, 32'h12345677, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h00000100, 32'h000000FF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset diff", 64'(diff), 64'd0);
        check("reset bout", 64'(bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: hold DONE while offering new operands.
        @(negedge clk);
        in_valid = 1'b1; a = 32'h12345678; b = 32'h00000001; bin = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("bp out_valid", 64'(out_valid), 64'd1);
        held_diff = diff;
        held_bout = bout;
        check("bp diff", 64'(held_diff), 64'h12345677);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0] ? 1'b0 : 1'b1;
            a = 32'hFFFFFFFF; b = 32'h0; bin = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d diff held", c), 64'(diff), 64'(held_diff));
            check($sformatf("bp%0d bout held", c), 64'(bout), 64'(held_bout));
            check($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release busy", 64'(busy), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp diff after", 64'(diff), 64'h12345677);

        // Reset while RUN is at idx = 2.
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h11111111; bin = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("mid busy before rst", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid in_ready", 64'(in_ready), 64'd1);
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid diff", 64'(diff), 64'd0);
        check("rst mid bout", 64'(bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        run_op(v, "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
